// File: rtl/adc128_pkg.sv
// Shared constants, FSM state type and frame-load helper for the
// ADC128S022 serial-interface responder.
package adc128_pkg;

  localparam int unsigned FRAME_BITS      = 16;
  localparam int unsigned LEAD_ZEROS      = 4;
  localparam int unsigned ADDR_EDGE_FIRST = 3;
  localparam int unsigned ADDR_W          = 3;
  localparam int unsigned DATA_W          = 12;
  localparam int unsigned NUM_CH          = 8;
  localparam int unsigned CNT_W           = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } resp_state_t;

  // Build the outgoing frame word: leading zeros followed by the selected sample.
  function automatic logic [FRAME_BITS-1:0] load_word(
    input logic [NUM_CH*DATA_W-1:0] ch_data,
    input logic [ADDR_W-1:0]        addr
  );
    logic [31:0] base;
    base = 32'(addr) * DATA_W;
    return {{LEAD_ZEROS{1'b0}}, ch_data[base +: DATA_W]};
  endfunction

endpackage

// File: rtl/adc128s022_responder_sync_edge_det.sv
// N-stage synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge_det #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc128s022_responder.sv
// ADC128S022 responder: emulates the ADC's serial interface toward an SPI
// master. The master samples dout on sck rising edges; the responder shifts
// on sck falling edges and captures the channel address from din on rising
// edges 3..5. Optional abort checking is enabled with ADC_RESP_ERR_CHECK_EN.
module adc128s022_responder
  import adc128_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic                     adc_sck,
  input  logic                     adc_cs_n,
  input  logic                     din,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     dout,
  output logic                     frame_done,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     frame_err,
  output logic [7:0]               err_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LO  = CNT_W'(ADDR_EDGE_FIRST - 1);
  localparam logic [CNT_W-1:0] ADDR_HI  = CNT_W'(ADDR_EDGE_FIRST - 2 + ADDR_W);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic din_s, din_rise_unused, din_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .async_in (adc_sck),
    .level    (sck_level_unused),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .async_in (adc_cs_n),
    .level    (cs_level_unused),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .async_in (din),
    .level    (din_s),
    .rise     (din_rise_unused),
    .fall     (din_fall_unused)
  );

  resp_state_t           state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0]     addr_cap_q, addr_cap_d;
  logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
  logic                  reload_pend_q, reload_pend_d;
  logic                  frame_done_q;
  logic                  done_d;
  logic                  abort_d;

  // Next-state and datapath decode; cs_n rising takes priority over sck edges.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    addr_cap_d    = addr_cap_q;
    cur_addr_d    = cur_addr_q;
    reload_pend_d = reload_pend_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d       = ACTIVE;
          bit_cnt_d     = '0;
          shift_d       = load_word(ch_data, cur_addr_q);
          reload_pend_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d       = IDLE;
          bit_cnt_d     = '0;
          shift_d       = '0;
          reload_pend_d = 1'b0;
          // A frame counts as aborted only once it has seen at least one
          // rising edge; a counter of zero means either nothing started or
          // the previous frame just completed on its 16th edge.
          abort_d       = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          if (bit_cnt_q >= ADDR_LO && bit_cnt_q <= ADDR_HI)
            addr_cap_d = {addr_cap_q[ADDR_W-2:0], din_s};
          if (bit_cnt_q == LAST_CNT) begin
            bit_cnt_d     = '0;
            cur_addr_d    = addr_cap_d;
            done_d        = 1'b1;
            reload_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          // The 16th falling edge follows the 16th rising edge, so a pending
          // reload marks it and the new cur_addr is already in place.
          if (reload_pend_q) begin
            shift_d       = load_word(ch_data, cur_addr_q);
            reload_pend_d = 1'b0;
          end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      addr_cap_q    <= '0;
      cur_addr_q    <= '0;
      reload_pend_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      addr_cap_q    <= addr_cap_d;
      cur_addr_q    <= cur_addr_d;
      reload_pend_q <= reload_pend_d;
      frame_done_q  <= done_d;
    end
  end

  assign dout       = (state_q == ACTIVE) & shift_q[FRAME_BITS-1];
  assign frame_done = frame_done_q;
  assign cur_addr   = cur_addr_q;

`ifdef ADC_RESP_ERR_CHECK_EN
  logic       frame_err_q;
  logic [7:0] err_count_q;

  // Abort pulse and saturating abort counter.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      frame_err_q <= abort_d;
      if (abort_d && (err_count_q != '1))
        err_count_q <= err_count_q + 1'b1;
    end
  end

  assign frame_err = frame_err_q;
  assign err_count = err_count_q;
`else
  logic abort_unused;
  assign abort_unused = abort_d;
  assign frame_err    = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_adc128s022_responder.sv
// Scoreboard bench for adc128s022_responder: the stimulus process pushes the
// expected dout word and post-frame cur_addr per frame; a monitor pops and
// compares on every frame_done pulse.
`timescale 1ns/1ps
module tb_adc128s022_responder;

  localparam int HALF = 200;  // sck half period in ns (2.5 MHz)
`ifdef ADC_RESP_ERR_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        adc_sck;
  logic        adc_cs_n;
  logic        din;
  logic [95:0] ch_data;
  logic        dout;
  logic        frame_done;
  logic [2:0]  cur_addr;
  logic        frame_err;
  logic [7:0]  err_count;

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int err_seen  = 0;

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mon_bits = '0;

  always #10 clk_50 = ~clk_50;

  adc128s022_responder #(.SYNC_STAGES(2)) dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .adc_sck    (adc_sck),
    .adc_cs_n   (adc_cs_n),
    .din        (din),
    .ch_data    (ch_data),
    .dout       (dout),
    .frame_done (frame_done),
    .cur_addr   (cur_addr),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master samples dout on each sck rising edge.
  always @(posedge adc_sck) mon_bits <= {mon_bits[14:0], dout};

  // Scoreboard monitor: each frame_done consumes one expected frame.
  always @(negedge clk_50) begin
    exp_t e;
    if (frame_done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got pulse expected none");
      end else begin
        e = exp_q.pop_front();
        check("frame_dout_word", {16'd0, mon_bits}, {16'd0, e.word});
        check("frame_cur_addr", {29'd0, cur_addr}, {29'd0, e.addr});
      end
    end
    if (frame_err) err_seen++;
  end

  task automatic cs_low();
    adc_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    adc_cs_n = 1'b1;
    #(2 * HALF);
  endtask

  // n full sck cycles (idle low); din carries addr on edges 3..5, fill elsewhere.
  task automatic sck_cycles(input logic [2:0] addr, input int n, input logic fill);
    for (int k = 1; k <= n; k++) begin
      case (k)
        3:       din = addr[2];
        4:       din = addr[1];
        5:       din = addr[0];
        default: din = fill;
      endcase
      #(HALF);
      adc_sck = 1'b1;
      #(HALF);
      adc_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [2:0] addr, input logic [15:0] word,
                       input logic [2:0] during, input string tag, input logic fill);
    exp_t e;
    e.word = word;
    e.addr = addr;
    exp_q.push_back(e);
    check({tag, "_cur_addr_during"}, {29'd0, cur_addr}, {29'd0, during});
    sck_cycles(addr, 16, fill);
  endtask

  initial begin
    rst_n    = 1'b0;
    adc_cs_n = 1'b1;
    adc_sck  = 1'b0;
    din      = 1'b0;
    // ch7..ch0
    ch_data  = {12'h7F0, 12'h6E9, 12'h123, 12'h444, 12'h333, 12'h2C4, 12'h111, 12'hA5C};
    repeat (3) @(negedge clk_50);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_cur_addr", {29'd0, cur_addr}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50);
    check("idle_dout", {31'd0, dout}, 32'd0);

    // First frame after reset converts ch0, din all zero.
    cs_low();  frame(3'd0, 16'h0A5C, 3'd0, "A", 1'b0); cs_high();
    // Address 5 requested; this frame still converts ch0.
    cs_low();  frame(3'd5, 16'h0A5C, 3'd0, "B", 1'b1); cs_high();
    // Converts ch5.
    cs_low();  frame(3'd0, 16'h0123, 3'd5, "C", 1'b1); cs_high();
    check("done_count_single", done_seen, 32'd3);

    // Continuous mode: cs_n held low across three frames.
    cs_low();
    frame(3'd6, 16'h0A5C, 3'd0, "D1", 1'b1);
    frame(3'd2, 16'h06E9, 3'd6, "D2", 1'b1);
    frame(3'd7, 16'h02C4, 3'd2, "D3", 1'b1);
    cs_high();
    check("done_count_cont", done_seen, 32'd6);
    check("cont_final_addr", {29'd0, cur_addr}, 32'd7);

    // Abort after 9 rising edges.
    cs_low();
    sck_cycles(3'd3, 9, 1'b1);
    cs_high();
    check("abort_no_done", done_seen, 32'd6);
    check("abort_cur_addr", {29'd0, cur_addr}, 32'd7);
    check("abort_dout", {31'd0, dout}, 32'd0);
    check("abort_err_pulses", err_seen, ERR_EN);
    check("abort_err_count", {24'd0, err_count}, ERR_EN);

    // 299 further aborts (300 total): counter saturates.
    repeat (299) begin
      cs_low();
      sck_cycles(3'd1, 1, 1'b1);
      cs_high();
    end
    check("sat_err_count", {24'd0, err_count}, ERR_EN * 255);
    check("sat_err_pulses", err_seen, ERR_EN * 300);
    check("sat_no_done", done_seen, 32'd6);
    check("sat_cur_addr", {29'd0, cur_addr}, 32'd7);

    // Reset asserted at sck rising edge 8 of a frame.
    cs_low();
    sck_cycles(3'd3, 7, 1'b1);
    din = 1'b1;
    #(HALF);
    adc_sck = 1'b1;
    #(60);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", {31'd0, dout}, 32'd0);
    check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    check("midrst_cur_addr", {29'd0, cur_addr}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_err_count", {24'd0, err_count}, 32'd0);
    adc_sck  = 1'b0;
    adc_cs_n = 1'b1;
    repeat (5) @(negedge clk_50);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50);
    cs_low();  frame(3'd0, 16'h0A5C, 3'd0, "R", 1'b1); cs_high();
    check("done_count_final", done_seen, 32'd7);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
